// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-requester memory arbiter:
//   - default data / address widths
//   - FSM state encoding
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_WIDTH = 8;   // data width in bits
    localparam int DEF_DEPTH = 4;   // address width in bits (2^DEPTH words)

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin selector. Purely combinational.
//   i_req0, i_req1 : request inputs
//   i_last         : requester granted most recently (0 or 1)
//   o_winner       : one-hot winner, bit N set when requester N is selected;
//                    all zero when nobody requests
// A lone requester always wins; on contention the requester that was not
// granted last wins.
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_last,
    output logic [1:0] o_winner
);

    always_comb begin
        o_winner = 2'b00;
        if (i_req0 && i_req1) begin
            o_winner = i_last ? 2'b01 : 2'b10;
        end else if (i_req0) begin
            o_winner = 2'b01;
        end else if (i_req1) begin
            o_winner = 2'b10;
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mem_rr_arbiter
// Arbitrates two requesters onto one synchronous single-port memory.
// Each access takes two cycles: an IDLE cycle in which requests are sampled,
// then an ACCESS cycle in which the registered memory command is presented.
// Read data is captured on the edge that ends ACCESS.
//
// Ports
//   clk, rst                    : clock, asynchronous active-high reset
//   req0/1, we0/1               : request and write-enable per requester
//   addr0/1, wrData0/1          : address and write data per requester
//   gnt0/1                      : one-cycle grant pulse (the ACCESS cycle)
//   rd_valid0/1                 : one-cycle pulse when rdData holds new data
//   rdData                      : last captured read data (shared)
//   busy                        : high during ACCESS
//   mem_we, mem_addr, mem_wrData: registered command to the memory
//   mem_rdData                  : combinational read data from the memory
// -----------------------------------------------------------------------------
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [DEPTH-1:0] addr0,
    input  logic [DEPTH-1:0] addr1,
    input  logic [WIDTH-1:0] wrData0,
    input  logic [WIDTH-1:0] wrData1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rd_valid0,
    output logic             rd_valid1,
    output logic [WIDTH-1:0] rdData,
    output logic             busy,
    output logic             mem_we,
    output logic [DEPTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wrData,
    input  logic [WIDTH-1:0] mem_rdData
);

    state_t           r_state;
    logic             r_last;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_rd_valid0;
    logic             r_rd_valid1;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_mem_we;
    logic [DEPTH-1:0] r_mem_addr;
    logic [WIDTH-1:0] r_mem_wrdata;

    state_t           w_state_nxt;
    logic             w_last_nxt;
    logic             w_gnt0_nxt;
    logic             w_gnt1_nxt;
    logic             w_rd_valid0_nxt;
    logic             w_rd_valid1_nxt;
    logic [WIDTH-1:0] w_rd_data_nxt;
    logic             w_mem_we_nxt;
    logic [DEPTH-1:0] w_mem_addr_nxt;
    logic [WIDTH-1:0] w_mem_wrdata_nxt;
    logic [1:0]       w_winner;

    rr_arb2 u_rr_arb2 (
        .i_req0   (req0),
        .i_req1   (req1),
        .i_last   (r_last),
        .o_winner (w_winner)
    );

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last       <= 1'b1;   // requester 0 wins the first contention
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_rd_valid0  <= 1'b0;
            r_rd_valid1  <= 1'b0;
            r_rd_data    <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wrdata <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            r_state      <= w_state_nxt;
            r_last       <= w_last_nxt;
            r_gnt0       <= w_gnt0_nxt;
            r_gnt1       <= w_gnt1_nxt;
            r_rd_valid0  <= w_rd_valid0_nxt;
            r_rd_valid1  <= w_rd_valid1_nxt;
            r_rd_data    <= w_rd_data_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wrdata <= w_mem_wrdata_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path leaves one unassigned and no latch is inferred.
        w_state_nxt      = r_state;
        w_last_nxt       = r_last;
        w_gnt0_nxt       = 1'b0;
        w_gnt1_nxt       = 1'b0;
        w_rd_valid0_nxt  = 1'b0;
        w_rd_valid1_nxt  = 1'b0;
        w_rd_data_nxt    = r_rd_data;
        w_mem_we_nxt     = 1'b0;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wrdata_nxt = r_mem_wrdata;

        case (r_state)
            ST_IDLE: begin
                if (w_winner != 2'b00) begin
                    w_state_nxt = ST_ACCESS;
                    w_gnt0_nxt  = w_winner[0];
                    w_gnt1_nxt  = w_winner[1];
                    w_last_nxt  = w_winner[1];
                    if (w_winner[0]) begin
                        w_mem_we_nxt     = we0;
                        w_mem_addr_nxt   = addr0;
                        w_mem_wrdata_nxt = wrData0;
                    end else begin
                        w_mem_we_nxt     = we1;
                        w_mem_addr_nxt   = addr1;
                        w_mem_wrdata_nxt = wrData1;
                    end
                end
            end

            ST_ACCESS: begin
                // Requests are ignored here. The grant register still
                // identifies the winner and mem_we tells read from write.
                w_state_nxt     = ST_IDLE;
                w_rd_valid0_nxt = r_gnt0 & ~r_mem_we;
                w_rd_valid1_nxt = r_gnt1 & ~r_mem_we;
                if (!r_mem_we) begin
                    w_rd_data_nxt = mem_rdData;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign gnt0       = r_gnt0;
    assign gnt1       = r_gnt1;
    assign rd_valid0  = r_rd_valid0;
    assign rd_valid1  = r_rd_valid1;
    assign rdData     = r_rd_data;
    assign busy       = (r_state == ST_ACCESS);
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wrData = r_mem_wrdata;

endmodule

// File: doc/mem_rr_arbiter.md
MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, address width in bits (memory holds 2^DEPTH words).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req0/req1  input  1  access request per requester.
REQ-006 SHALL have ports we0/we1  input  1  1 = write, 0 = read, qualified by reqN.
REQ-007 SHALL have ports addr0/addr1  input  DEPTH  access address per requester.
REQ-008 SHALL have ports wrData0/wrData1  input  WIDTH  write data per requester.
REQ-009 SHALL have ports gnt0/gnt1  output  1  one-cycle grant pulse, registered.
REQ-010 SHALL have ports rd_valid0/rd_valid1  output  1  one-cycle read-data-valid pulse, registered.
REQ-011 SHALL have port rdData  output  WIDTH  captured read data, shared by both requesters.
REQ-012 SHALL have port busy  output  1  high while in ACCESS.
REQ-013 SHALL have ports mem_we  output  1, mem_addr  output  DEPTH, mem_wrData  output  WIDTH: registered command to synchronous memory.
REQ-014 SHALL have port mem_rdData  input  WIDTH  combinational read data from memory.

Function
REQ-015 SHALL implement FSM states IDLE and ACCESS; reset state IDLE.
REQ-016 In IDLE with no request, SHALL stay IDLE, mem_we=0, mem_addr/mem_wrData held.
REQ-017 In IDLE with any reqN=1 at a clock edge, SHALL select one requester, register its we/addr/wrData onto mem_we/mem_addr/mem_wrData, set gnt of winner=1, go to ACCESS.
REQ-018 Selection SHALL be round-robin: single requester always wins; if both request, the one not granted last wins.
REQ-019 Last-granted pointer SHALL reset to 1, so requester 0 wins the first contention.
REQ-020 In ACCESS, gnt of winner SHALL be high for exactly that cycle; busy=1; request inputs SHALL NOT be sampled.
REQ-021 On the edge ending ACCESS: mem_we SHALL clear to 0; state SHALL return to IDLE; gnt SHALL clear.
REQ-022 For a read, on the edge ending ACCESS, SHALL capture mem_rdData into rdData and pulse rd_valid of winner for the following cycle only.
REQ-023 For a write, rd_valid SHALL stay 0; the write commits to memory at the edge ending ACCESS.
REQ-024 rdData SHALL hold its value until the next read capture.
REQ-025 Latency: req sampled at edge E -> gnt and memory command in cycle E..E+1 -> read data valid in cycle after E+1; throughput one access per two cycles.
REQ-026 Requesters SHALL keep reqN/weN/addrN/wrDataN stable until gnt seen and drop or change req within the gnt cycle; a req still high in the following IDLE cycle is a new request.
REQ-027 gnt0 and gnt1 SHALL never be high together; rd_valid0 and rd_valid1 SHALL never be high together.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, gnt0/1=0, rd_valid0/1=0, busy=0, mem_we=0, mem_addr=0, mem_wrData=0, rdData=0, pointer=1.
REQ-029 Reset during ACCESS SHALL abort the access: write not committed, read not returned; requester must re-request.

Structure
REQ-030 Shared package mem_arb_pkg SHALL hold the FSM state encoding and default WIDTH/DEPTH constants.
REQ-031 Round-robin selection SHALL be a sub-module rr_arb2 (inputs req0, req1, last pointer; output one-hot winner).

Verification
REQ-032 Single write then read: req0 write addr=3 data=0xA5, then req0 read addr=3 -> gnt0 pulses twice, rd_valid0 pulses once, rdData=0xA5.
REQ-033 Contention: req0 and req1 held high continuously after reset -> grants alternate gnt0, gnt1, gnt0, gnt1, one grant every 2 cycles.
REQ-034 Cross-requester: req1 writes addr=15 data=0x3C, req0 reads addr=15 -> rd_valid0 only, rdData=0x3C, rd_valid1 stays 0.
REQ-035 Reset mid-write: req0 write addr=5 data=0xFF, assert rst during ACCESS; previous addr=5 content 0x11 -> read after reset returns 0x11; all outputs 0 during reset.
REQ-036 Idle hold: no requests for 10 cycles after read of 0x5A -> mem_we=0, busy=0, rdData stays 0x5A, no gnt or rd_valid pulses.
